// File: rtl/tmds_pattern_gen_pkg.sv
// Shared definitions for the TMDS test-symbol source: pattern modes, FSM states,
// clock/control-token constants and per-channel PRBS seeding.
package tmds_pattern_gen_pkg;

  typedef enum logic [2:0] {
    MODE_IDLE  = 3'd0,
    MODE_PRBS  = 3'd1,
    MODE_CLOCK = 3'd2,
    MODE_CONST = 3'd3,
    MODE_RAMP  = 3'd4,
    MODE_CTRL  = 3'd5
  } mode_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARM,
    ST_RUN,
    ST_DONE
  } state_t;

  localparam logic [9:0] CLK_PAT_LO = 10'h01F;
  localparam logic [9:0] CLK_PAT_HI = 10'h3E0;

  localparam logic [9:0] CTRL_TOK0 = 10'h354;
  localparam logic [9:0] CTRL_TOK1 = 10'h0AB;
  localparam logic [9:0] CTRL_TOK2 = 10'h154;
  localparam logic [9:0] CTRL_TOK3 = 10'h2AB;

  function automatic logic [9:0] ctrl_token(logic [1:0] sel);
    logic [9:0] tok;
    case (sel)
      2'd0:    tok = CTRL_TOK0;
      2'd1:    tok = CTRL_TOK1;
      2'd2:    tok = CTRL_TOK2;
      default: tok = CTRL_TOK3;
    endcase
    return tok;
  endfunction

  // An all-zero LFSR would lock up, so a colliding seed is replaced.
  function automatic logic [14:0] chan_seed(logic [14:0] base, int unsigned n);
    logic [14:0] s;
    s = base ^ 15'(n << 4);
    if (s == '0) s = 15'h7FFF;
    return s;
  endfunction

endpackage

// File: rtl/tmds_pattern_gen_prbs15_step.sv
// Combinational multi-bit advance of a PRBS15 (x^15+x^14+1) Fibonacci LFSR.
// Emits SYMBOL_WIDTH bits MSB-first and the register state after those bits.
module tmds_pattern_gen_prbs15_step #(
  parameter int unsigned SYMBOL_WIDTH = 10
) (
  input  logic [14:0]             state,
  output logic [SYMBOL_WIDTH-1:0] symbol,
  output logic [14:0]             next_state
);

  logic [14:0] s;

  always_comb begin
    s      = state;
    symbol = '0;
    for (int unsigned i = 0; i < SYMBOL_WIDTH; i++) begin
      symbol = {symbol[SYMBOL_WIDTH-2:0], s[14]};
      s      = {s[13:0], s[14] ^ s[13]};
    end
    next_state = s;
  end

endmodule

// File: rtl/tmds_pattern_gen.sv
// Multi-channel TMDS test-symbol source: PRBS15/clock/const/ramp/control-token
// patterns, finite or continuous bursts, lockstep stall and single-symbol error injection.
module tmds_pattern_gen
  import tmds_pattern_gen_pkg::*;
#(
  parameter int unsigned NUM_CHANNELS = 3,
  parameter int unsigned SYMBOL_WIDTH = 10,
  parameter logic [14:0] SEED_BASE    = 15'h1,
  parameter int unsigned COUNT_WIDTH  = 32
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic                                 enable_i,
  input  logic [2:0]                           mode_i,
  input  logic [SYMBOL_WIDTH-1:0]              const_symbol_i,
  input  logic [15:0]                          burst_len_i,
  input  logic                                 inject_err_i,
  input  logic [1:0]                           inject_ch_i,
  input  logic [NUM_CHANNELS-1:0]              symbol_fifo_full_i,
  output logic                                 write_symbol_o,
  output logic [NUM_CHANNELS*SYMBOL_WIDTH-1:0] symbols_o,
  output logic                                 busy_o,
  output logic                                 done_o,
  output logic [COUNT_WIDTH-1:0]               symbol_count_o
);

  localparam int unsigned NC = NUM_CHANNELS;
  localparam int unsigned SW = SYMBOL_WIDTH;

  state_t          state;
  mode_t           mode;
  logic [SW-1:0]   const_sym;
  logic [SW-1:0]   idx;
  logic [15:0]     remaining;
  logic            continuous;
  logic            enable_prev;
  logic            pending;

  logic            write;
  logic            start;
  logic            last_write;
  logic            accept_inj;
  logic [NC*SW-1:0] next_symbols;
  logic [NC*SW-1:0] err_mask;

  assign write          = (state == ST_RUN) & ~|symbol_fifo_full_i & enable_i;
  assign write_symbol_o = write;
  assign start          = (state == ST_IDLE) && enable_i && !enable_prev &&
                          (mode_i >= 3'd1) && (mode_i <= 3'd5);
  assign last_write     = write && !continuous && (remaining == 16'd1);
  // Pending covers the window until the corrupted symbol is actually written.
  assign accept_inj     = inject_err_i && !pending && (state == ST_RUN) && enable_i &&
                          (32'(inject_ch_i) < NC);

  for (genvar n = 0; n < NC; n++) begin : g_ch
    logic [14:0]   lfsr;
    logic [14:0]   lfsr_adv;
    logic [SW-1:0] prbs_sym;
    logic [SW-1:0] pattern;
    logic          flip;

    tmds_pattern_gen_prbs15_step #(
      .SYMBOL_WIDTH(SW)
    ) u_step (
      .state     (lfsr),
      .symbol    (prbs_sym),
      .next_state(lfsr_adv)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        lfsr <= chan_seed(SEED_BASE, n);
      end else if (start) begin
        lfsr <= chan_seed(SEED_BASE, n);
      end else if (state == ST_ARM || write) begin
        lfsr <= lfsr_adv;
      end
    end

    always_comb begin
      case (mode)
        MODE_PRBS:  pattern = prbs_sym;
        MODE_CLOCK: pattern = idx[0] ? SW'(CLK_PAT_HI) : SW'(CLK_PAT_LO);
        MODE_CONST: pattern = const_sym;
        MODE_RAMP:  pattern = idx;
        MODE_CTRL:  pattern = SW'(ctrl_token(idx[1:0]));
        default:    pattern = '0;
      endcase
    end

    assign flip                      = accept_inj && (32'(inject_ch_i) == n);
    assign next_symbols[n*SW +: SW]  = pattern;
    assign err_mask[n*SW +: SW]      = {{(SW-1){1'b0}}, flip};
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state          <= ST_IDLE;
      mode           <= MODE_IDLE;
      const_sym      <= '0;
      idx            <= '0;
      remaining      <= '0;
      continuous     <= 1'b0;
      enable_prev    <= 1'b0;
      pending        <= 1'b0;
      symbols_o      <= '0;
      busy_o         <= 1'b0;
      done_o         <= 1'b0;
      symbol_count_o <= '0;
    end else begin
      enable_prev <= enable_i;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state          <= ST_ARM;
            mode           <= mode_t'(mode_i);
            const_sym      <= const_symbol_i;
            remaining      <= burst_len_i;
            continuous     <= (burst_len_i == 16'd0);
            idx            <= '0;
            symbol_count_o <= '0;
            busy_o         <= 1'b1;
          end
        end
        ST_ARM: begin
          state     <= ST_RUN;
          symbols_o <= next_symbols;
          idx       <= idx + SW'(1);
          pending   <= 1'b0;
        end
        ST_RUN: begin
          if (!enable_i) begin
            state  <= ST_IDLE;
            busy_o <= 1'b0;
          end else begin
            if (write) begin
              symbols_o <= next_symbols ^ err_mask;
              idx       <= idx + SW'(1);
              if (symbol_count_o != '1) symbol_count_o <= symbol_count_o + COUNT_WIDTH'(1);
              if (!continuous) remaining <= remaining - 16'd1;
              if (last_write) begin
                state  <= ST_DONE;
                busy_o <= 1'b0;
                done_o <= 1'b1;
              end
            end else if (accept_inj) begin
              symbols_o <= symbols_o ^ err_mask;
            end
            if (accept_inj)  pending <= 1'b1;
            else if (write)  pending <= 1'b0;
          end
        end
        ST_DONE: begin
          state  <= ST_IDLE;
          done_o <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tmds_pattern_gen.sv
// Self-checking bench for tmds_pattern_gen: randomized stalls/modes checked against
// a bit-sequence PRBS model and arithmetic pattern rules.
module tb_tmds_pattern_gen;

  localparam int NC = 3;
  localparam int SW = 10;
  localparam int CW = 32;
  localparam logic [14:0] SEED = 15'h1;

  logic              clk;
  logic              rst;
  logic              enable;
  logic [2:0]        mode;
  logic [SW-1:0]     const_sym;
  logic [15:0]       burst_len;
  logic              inject_err;
  logic [1:0]        inject_ch;
  logic [NC-1:0]     full;
  logic              write_symbol;
  logic [NC*SW-1:0]  symbols;
  logic              busy;
  logic              done;
  logic [CW-1:0]     symbol_count;

  int checks = 0;
  int passed = 0;

  tmds_pattern_gen #(
    .NUM_CHANNELS(NC),
    .SYMBOL_WIDTH(SW),
    .SEED_BASE   (SEED),
    .COUNT_WIDTH (CW)
  ) dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .enable_i          (enable),
    .mode_i            (mode),
    .const_symbol_i    (const_sym),
    .burst_len_i       (burst_len),
    .inject_err_i      (inject_err),
    .inject_ch_i       (inject_ch),
    .symbol_fifo_full_i(full),
    .write_symbol_o    (write_symbol),
    .symbols_o         (symbols),
    .busy_o            (busy),
    .done_o            (done),
    .symbol_count_o    (symbol_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // PRBS15 as a bit sequence: b[n+15] = b[n] ^ b[n+1], seed bits oldest-first.
  function automatic logic [SW-1:0] prbs_sym(int ch, int k);
    bit q[$];
    logic [14:0] sd;
    logic [SW-1:0] s;
    sd = SEED ^ 15'(ch << 4);
    if (sd == 15'd0) sd = 15'h7FFF;
    for (int i = 14; i >= 0; i--) q.push_back(sd[i]);
    for (int j = 0; q.size() < (k + 1) * SW; j++) q.push_back(q[j] ^ q[j+1]);
    s = '0;
    for (int i = 0; i < SW; i++) s = {s[SW-2:0], q[k*SW+i]};
    return s;
  endfunction

  function automatic logic [SW-1:0] exp_sym(int m, int ch, int k, logic [SW-1:0] c);
    logic [9:0] tok [4];
    tok = '{10'h354, 10'h0AB, 10'h154, 10'h2AB};
    case (m)
      1:       return prbs_sym(ch, k);
      2:       return (k % 2 == 0) ? SW'(10'h01F) : SW'(10'h3E0);
      3:       return c;
      4:       return SW'(k % (1 << SW));
      5:       return SW'(tok[k % 4]);
      default: return '0;
    endcase
  endfunction

  function automatic logic [NC*SW-1:0] exp_vec(int m, int k, logic [SW-1:0] c);
    logic [NC*SW-1:0] v;
    v = '0;
    for (int ch = 0; ch < NC; ch++) v[ch*SW +: SW] = exp_sym(m, ch, k, c);
    return v;
  endfunction

  task automatic tick(input logic en, input logic [NC-1:0] f, input logic inj, input logic [1:0] ich);
    @(negedge clk);
    enable = en; full = f; inject_err = inj; inject_ch = ich;
    #1;
  endtask

  task automatic setup_run(input logic [2:0] m, input logic [SW-1:0] c, input logic [15:0] bl);
    mode = m; const_sym = c; burst_len = bl;
    tick(1'b0, '0, 1'b0, 2'd0);
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    checks++; if (symbols !== '0) $display("FAIL reset_symbols got %h exp 0", symbols); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", busy); else passed++;
    checks++; if (done !== 1'b0) $display("FAIL reset_done got %b exp 0", done); else passed++;
    checks++; if (symbol_count !== '0) $display("FAIL reset_count got %0d exp 0", symbol_count); else passed++;
    rst = 1'b0;
    tick(1'b0, '0, 1'b0, 2'd0);
    checks++; if (write_symbol !== 1'b0) $display("FAIL reset_write got %b exp 0", write_symbol); else passed++;
  endtask

  task automatic run_prbs8(input string tag);
    int w = 0, dn = 0, dn_at = -1;
    setup_run(3'd1, '0, 16'd8);
    for (int cyc = 0; cyc < 30; cyc++) begin
      tick(1'b1, '0, 1'b0, 2'd0);
      if (write_symbol) begin
        checks++;
        if (symbols !== exp_vec(1, w, '0))
          $display("FAIL %s_sym%0d got %h exp %h", tag, w, symbols, exp_vec(1, w, '0));
        else passed++;
        w++;
      end
      if (done) begin dn++; dn_at = w; end
    end
    checks++; if (w !== 8) $display("FAIL %s_writes got %0d exp 8", tag, w); else passed++;
    checks++; if (dn !== 1) $display("FAIL %s_done_pulses got %0d exp 1", tag, dn); else passed++;
    checks++; if (dn_at !== 8) $display("FAIL %s_done_after got %0d exp 8", tag, dn_at); else passed++;
    checks++; if (symbol_count !== 32'd8) $display("FAIL %s_count got %0d exp 8", tag, symbol_count); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL %s_busy_end got %b exp 0", tag, busy); else passed++;
    tick(1'b0, '0, 1'b0, 2'd0);
  endtask

  task automatic test_prbs_burst;
    run_prbs8("t1");
  endtask

  task automatic test_clock_stall;
    int w = 0, dn = 0;
    logic [NC-1:0] f;
    setup_run(3'd2, '0, 16'd12);
    for (int cyc = 0; cyc < 80; cyc++) begin
      f = ((cyc / 3) % 2 == 1) ? 3'b010 : 3'b000;
      if ($urandom % 5 == 0) f[0] = 1'b1;
      tick(1'b1, f, 1'b0, 2'd0);
      if (|f) begin
        checks++;
        if (write_symbol !== 1'b0) $display("FAIL t2_stall got %b exp 0 (cyc %0d)", write_symbol, cyc); else passed++;
      end else if (w > 0 && w < 12) begin
        checks++;
        if (write_symbol !== 1'b1) $display("FAIL t2_nostall got %b exp 1 (cyc %0d)", write_symbol, cyc); else passed++;
      end
      if (write_symbol) begin
        checks++;
        if (symbols !== exp_vec(2, w, '0)) $display("FAIL t2_sym%0d got %h exp %h", w, symbols, exp_vec(2, w, '0));
        else passed++;
        w++;
      end
      if (done) dn++;
    end
    checks++; if (w !== 12) $display("FAIL t2_writes got %0d exp 12", w); else passed++;
    checks++; if (dn !== 1) $display("FAIL t2_done_pulses got %0d exp 1", dn); else passed++;
    tick(1'b0, '0, 1'b0, 2'd0);
  endtask

  task automatic test_ctrl_abort;
    int w = 0, dn = 0;
    logic en = 1'b1;
    logic [NC-1:0] f;
    setup_run(3'd5, '0, 16'd0);
    for (int cyc = 0; cyc < 40; cyc++) begin
      f = ($urandom % 3 == 0) ? NC'($urandom) : '0;
      tick(en, f, 1'b0, 2'd0);
      if (write_symbol) begin
        checks++;
        if (symbols !== exp_vec(5, w, '0)) $display("FAIL t3_sym%0d got %h exp %h", w, symbols, exp_vec(5, w, '0));
        else passed++;
        w++;
      end
      if (done) dn++;
      if (w == 6) en = 1'b0;
    end
    checks++; if (w !== 6) $display("FAIL t3_writes got %0d exp 6", w); else passed++;
    checks++; if (dn !== 0) $display("FAIL t3_done_on_abort got %0d exp 0", dn); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL t3_busy_end got %b exp 0", busy); else passed++;
    checks++; if (symbol_count !== 32'd6) $display("FAIL t3_count got %0d exp 6", symbol_count); else passed++;
  endtask

  task automatic test_ramp_long;
    int w = 0, dn = 0;
    logic [NC-1:0] f;
    setup_run(3'd4, '0, 16'd1030);
    for (int cyc = 0; cyc < 1500 && dn == 0; cyc++) begin
      f = ($urandom % 8 == 0) ? NC'(1 << ($urandom % NC)) : '0;
      tick(1'b1, f, 1'b0, 2'd0);
      if (write_symbol) begin
        checks++;
        if (symbols !== exp_vec(4, w, '0)) $display("FAIL t4_sym%0d got %h exp %h", w, symbols, exp_vec(4, w, '0));
        else passed++;
        w++;
      end
      if (done) dn++;
    end
    checks++; if (w !== 1030) $display("FAIL t4_writes got %0d exp 1030", w); else passed++;
    checks++; if (dn !== 1) $display("FAIL t4_done_pulses got %0d exp 1", dn); else passed++;
    checks++; if (symbol_count !== 32'd1030) $display("FAIL t4_count got %0d exp 1030", symbol_count); else passed++;
    tick(1'b0, '0, 1'b0, 2'd0);
  endtask

  task automatic test_const_inject;
    int w = 0, dn = 0, stage = 0, bad_idx = -1;
    logic [NC-1:0] f;
    logic inj;
    logic [1:0] ich;
    logic [NC*SW-1:0] e;
    setup_run(3'd3, SW'(10'h2AA), 16'd8);
    for (int cyc = 0; cyc < 80; cyc++) begin
      f = ($urandom % 4 == 0) ? NC'(1 << ($urandom % NC)) : '0;
      inj = 1'b0; ich = 2'd0;
      if (stage == 0 && w == 3) begin
        f = 3'b001; inj = 1'b1; ich = 2'd2; stage = 1; bad_idx = 3;
      end else if (stage == 1) begin
        f = 3'b100; inj = 1'b1; ich = 2'd0; stage = 2;
      end else if (stage == 2 && w == 5) begin
        f = 3'b010; inj = 1'b1; ich = 2'd3; stage = 3;
      end
      tick(1'b1, f, inj, ich);
      if (write_symbol) begin
        e = exp_vec(3, w, SW'(10'h2AA));
        if (w == bad_idx) e[2*SW] = ~e[2*SW];
        checks++;
        if (symbols !== e) $display("FAIL t5_sym%0d got %h exp %h", w, symbols, e);
        else passed++;
        w++;
      end
      if (done) dn++;
    end
    checks++; if (w !== 8) $display("FAIL t5_writes got %0d exp 8", w); else passed++;
    checks++; if (dn !== 1) $display("FAIL t5_done_pulses got %0d exp 1", dn); else passed++;
    tick(1'b0, '0, 1'b0, 2'd0);
  endtask

  task automatic test_async_reset;
    int w = 0;
    setup_run(3'd1, '0, 16'd8);
    for (int cyc = 0; cyc < 20 && w < 4; cyc++) begin
      tick(1'b1, '0, 1'b0, 2'd0);
      if (write_symbol) w++;
    end
    checks++; if (busy !== 1'b1) $display("FAIL t6_busy_pre got %b exp 1", busy); else passed++;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++; if (symbols !== '0) $display("FAIL t6_symbols got %h exp 0", symbols); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL t6_busy got %b exp 0", busy); else passed++;
    checks++; if (symbol_count !== '0) $display("FAIL t6_count got %0d exp 0", symbol_count); else passed++;
    checks++; if (write_symbol !== 1'b0) $display("FAIL t6_write got %b exp 0", write_symbol); else passed++;
    @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    run_prbs8("t6");
  endtask

  task automatic test_random_modes;
    for (int it = 0; it < 6; it++) begin
      int w = 0, dn = 0, m, bl;
      logic [SW-1:0] c;
      logic [NC-1:0] f;
      m  = int'($urandom_range(1, 5));
      bl = int'($urandom_range(1, 24));
      c  = SW'($urandom);
      setup_run(3'(m), c, 16'(bl));
      for (int cyc = 0; cyc < 150 && dn == 0; cyc++) begin
        f = ($urandom % 4 == 0) ? NC'($urandom) : '0;
        tick(1'b1, f, 1'b0, 2'd0);
        if (write_symbol) begin
          checks++;
          if (symbols !== exp_vec(m, w, c))
            $display("FAIL rnd%0d_m%0d_sym%0d got %h exp %h", it, m, w, symbols, exp_vec(m, w, c));
          else passed++;
          w++;
        end
        if (done) dn++;
      end
      checks++; if (w !== bl) $display("FAIL rnd%0d_writes got %0d exp %0d", it, w, bl); else passed++;
      checks++; if (symbol_count !== CW'(bl)) $display("FAIL rnd%0d_count got %0d exp %0d", it, symbol_count, bl); else passed++;
      checks++; if (dn !== 1) $display("FAIL rnd%0d_done got %0d exp 1", it, dn); else passed++;
      tick(1'b0, '0, 1'b0, 2'd0);
    end
  endtask

  task automatic test_idle_modes;
    int busy_seen = 0, wr_seen = 0;
    for (int m = 6; m <= 8; m++) begin
      setup_run(3'(m % 8), '0, 16'd4);
      for (int cyc = 0; cyc < 6; cyc++) begin
        tick(1'b1, '0, 1'b0, 2'd0);
        if (busy) busy_seen++;
        if (write_symbol) wr_seen++;
      end
    end
    checks++; if (busy_seen !== 0) $display("FAIL idle_modes_busy got %0d exp 0", busy_seen); else passed++;
    checks++; if (wr_seen !== 0) $display("FAIL idle_modes_write got %0d exp 0", wr_seen); else passed++;
    tick(1'b0, '0, 1'b0, 2'd0);
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; mode = 3'd0; const_sym = '0; burst_len = '0;
    inject_err = 1'b0; inject_ch = 2'd0; full = '0;
    test_reset();
    test_prbs_burst();
    test_clock_stall();
    test_ctrl_abort();
    test_ramp_long();
    test_const_inject();
    test_async_reset();
    test_random_modes();
    test_idle_modes();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
